fft_sweep_control: RTL and testbench

Multi-point frequency-sweep scheduler for the impedance-measurement FFT path. For each of up to `N_MAX` frequency points it programs the DDS tuning word, waits a settling interval, pulses the FFT core reset, selects the FFT output bin for that point, and waits for the FFT completion strobe. It then emits a per-point result strobe and advances. It sits between the host/register block and the single-point FFT datapath, replacing manual per-point control.

---
 rtl/imp_meas_pkg.sv | 22 ++
 rtl/fft_sweep_control_if.sv | 48 ++++
 rtl/cycle_timer.sv | 30 +++
 rtl/fft_sweep_control.sv | 179 +++++++++++++++++
 tb/tb_fft_sweep_control.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imp_meas_pkg.sv
// Shared definitions for the impedance-measurement FFT path: sweep FSM states
// and default datapath widths.
package imp_meas_pkg;

  localparam int DEF_FFT_LEN    = 2048;
  localparam int DEF_FTW_W      = 32;
  localparam int DEF_ADDR_W     = $clog2(DEF_FFT_LEN);
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_N_MAX      = 64;
  localparam int DEF_RST_CYCLES = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_FRST,
    S_WAIT,
    S_STORE,
    S_NEXT
  } sweep_state_e;

endpackage

// File: rtl/fft_sweep_control_if.sv
// Host/FFT-side signal bundle of the sweep scheduler; master drives the
// configuration and fft_done, slave is the scheduler itself.
interface fft_sweep_control_if
  import imp_meas_pkg::*;
#(
  parameter int N_MAX  = DEF_N_MAX,
  parameter int FTW_W  = DEF_FTW_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
);
  localparam int PIDX_W = $clog2(N_MAX) + 1;

  logic              start;
  logic              abort;
  logic [PIDX_W-1:0] n_points;
  logic [FTW_W-1:0]  ftw_base;
  logic [FTW_W-1:0]  ftw_step;
  logic [ADDR_W-1:0] bin_base;
  logic [ADDR_W-1:0] bin_step;
  logic [CNT_W-1:0]  settle_cycles;
  logic [CNT_W-1:0]  timeout_cycles;
  logic              fft_done;

  logic [FTW_W-1:0]  dds_ftw;
  logic              dds_load;
  logic              fft_reset;
  logic [ADDR_W-1:0] reg_addr;
  logic [PIDX_W-1:0] point_idx;
  logic              result_valid;
  logic              busy;
  logic              sweep_done;
  logic              timeout_err;

  modport master (
    output start, abort, n_points, ftw_base, ftw_step, bin_base, bin_step,
           settle_cycles, timeout_cycles, fft_done,
    input  dds_ftw, dds_load, fft_reset, reg_addr, point_idx, result_valid,
           busy, sweep_done, timeout_err
  );

  modport slave (
    input  start, abort, n_points, ftw_base, ftw_step, bin_base, bin_step,
           settle_cycles, timeout_cycles, fft_done,
    output dds_ftw, dds_load, fft_reset, reg_addr, point_idx, result_valid,
           busy, sweep_done, timeout_err
  );

endinterface

// File: rtl/cycle_timer.sv
// Loadable down-counter; expired_o is high in the last cycle of a loaded
// interval, so a load of 0 or 1 both give a one-cycle interval.
module cycle_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         tick_i,
  output logic         expired_o
);

  logic [W-1:0] count_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (tick_i && count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expired_o = (count_q <= W'(1));

endmodule

// File: rtl/fft_sweep_control.sv
// Multi-point frequency-sweep scheduler: per point it loads the DDS, settles,
// resets the FFT core, waits for completion and strobes the result.
module fft_sweep_control
  import imp_meas_pkg::*;
#(
  parameter int N_MAX      = DEF_N_MAX,
  parameter int FTW_W      = DEF_FTW_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int RST_CYCLES = DEF_RST_CYCLES
) (
  input logic               clk,
  input logic               rst,
  fft_sweep_control_if.slave bus
);

  localparam int PIDX_W = $clog2(N_MAX) + 1;

  sweep_state_e      state_q;
  logic [PIDX_W-1:0] npts_q;
  logic [FTW_W-1:0]  ftw_step_q;
  logic [ADDR_W-1:0] bin_step_q;
  logic [CNT_W-1:0]  settle_q;
  logic [CNT_W-1:0]  timeout_q;

  logic [FTW_W-1:0]  dds_ftw_q;
  logic              dds_load_q;
  logic              fft_reset_q;
  logic [ADDR_W-1:0] reg_addr_q;
  logic [PIDX_W-1:0] point_idx_q;
  logic              result_valid_q;
  logic              busy_q;
  logic              sweep_done_q;
  logic              timeout_err_q;

  logic [PIDX_W-1:0] npts_d;
  logic              tmr_load_d;
  logic [CNT_W-1:0]  tmr_val_d;
  logic              tmr_expired;

  always_comb begin
    npts_d = bus.n_points;
    if (bus.n_points > PIDX_W'(N_MAX)) npts_d = PIDX_W'(N_MAX);
  end

  // The timer is armed on the edge that enters SETTLE, FRST and WAIT.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    tmr_load_d = 1'b0;
    tmr_val_d  = settle_q;
    unique case (state_q)
      S_LOAD: tmr_load_d = 1'b1;
      S_SETTLE: begin
        tmr_load_d = tmr_expired;
        tmr_val_d  = CNT_W'(RST_CYCLES);
      end
      S_FRST: begin
        tmr_load_d = tmr_expired;
        tmr_val_d  = timeout_q;
      end
      default: ;
    endcase
  end

  cycle_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load_d),
    .load_val_i (tmr_val_d),
    .tick_i     (!tmr_load_d),
    .expired_o  (tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      npts_q         <= '0;
      ftw_step_q     <= '0;
      bin_step_q     <= '0;
      settle_q       <= '0;
      timeout_q      <= '0;
      dds_ftw_q      <= '0;
      dds_load_q     <= 1'b0;
      fft_reset_q    <= 1'b1;
      reg_addr_q     <= '0;
      point_idx_q    <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      sweep_done_q   <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      dds_load_q     <= 1'b0;
      result_valid_q <= 1'b0;
      sweep_done_q   <= 1'b0;

      if (state_q != S_IDLE && bus.abort) begin
        // Idle always holds the FFT core in reset, including after an abort.
        state_q     <= S_IDLE;
        busy_q      <= 1'b0;
        fft_reset_q <= 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (bus.start) begin
              if (bus.n_points == '0) begin
                sweep_done_q <= 1'b1;
              end else begin
                npts_q        <= npts_d;
                ftw_step_q    <= bus.ftw_step;
                bin_step_q    <= bus.bin_step;
                settle_q      <= bus.settle_cycles;
                timeout_q     <= bus.timeout_cycles;
                dds_ftw_q     <= bus.ftw_base;
                reg_addr_q    <= bus.bin_base;
                point_idx_q   <= '0;
                timeout_err_q <= 1'b0;
                dds_load_q    <= 1'b1;
                fft_reset_q   <= 1'b0;
                busy_q        <= 1'b1;
                state_q       <= S_LOAD;
              end
            end
          end
          S_LOAD: state_q <= S_SETTLE;
          S_SETTLE: begin
            if (tmr_expired) begin
              fft_reset_q <= 1'b1;
              state_q     <= S_FRST;
            end
          end
          S_FRST: begin
            if (tmr_expired) begin
              fft_reset_q <= 1'b0;
              state_q     <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (bus.fft_done) begin
              result_valid_q <= 1'b1;
              state_q        <= S_STORE;
            end else if (timeout_q != '0 && tmr_expired) begin
              timeout_err_q <= 1'b1;
              busy_q        <= 1'b0;
              fft_reset_q   <= 1'b1;
              state_q       <= S_IDLE;
            end
          end
          S_STORE: state_q <= S_NEXT;
          S_NEXT: begin
            if (point_idx_q == npts_q - PIDX_W'(1)) begin
              sweep_done_q <= 1'b1;
              busy_q       <= 1'b0;
              fft_reset_q  <= 1'b1;
              state_q      <= S_IDLE;
            end else begin
              point_idx_q <= point_idx_q + PIDX_W'(1);
              dds_ftw_q   <= dds_ftw_q + ftw_step_q;
              reg_addr_q  <= reg_addr_q + bin_step_q;
              dds_load_q  <= 1'b1;
              state_q     <= S_LOAD;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.dds_ftw      = dds_ftw_q;
  assign bus.dds_load     = dds_load_q;
  assign bus.fft_reset    = fft_reset_q;
  assign bus.reg_addr     = reg_addr_q;
  assign bus.point_idx    = point_idx_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;
  assign bus.sweep_done   = sweep_done_q;
  assign bus.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_fft_sweep_control.sv
// Bench for fft_sweep_control: table of sweep configurations plus hand-built
// timing, timeout, abort, zero-point and reset sequences, with a scoreboard.
module tb_fft_sweep_control;
  import imp_meas_pkg::*;

  localparam int N_MAX = 64;
  localparam int RSTC  = 4;
  localparam int SIG_FRST = 0;
  localparam int SIG_BUSY = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_sweep_control_if #(.N_MAX(N_MAX), .FTW_W(32), .ADDR_W(11), .CNT_W(16)) bus ();

  fft_sweep_control #(
    .N_MAX(N_MAX), .FTW_W(32), .ADDR_W(11), .CNT_W(16), .RST_CYCLES(RSTC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          n;
    logic [31:0] ftw_base, ftw_step;
    logic [10:0] bin_base, bin_step;
    logic [15:0] settle, tmo;
    int          delay;      // WAIT cycles before fft_done; <0 means never
    int          exp_res;
    int          exp_done;
    logic        exp_tmo;
    logic [31:0] exp_ftw1;
    logic [10:0] exp_addr1;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] ftw;
    logic [10:0] addr;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int res_cnt  = 0;
  int done_cnt = 0;
  int load_cnt = 0;
  logic [31:0] seen_ftw1;
  logic [10:0] seen_addr1;

  logic [31:0] cur_ftw_base, cur_ftw_step;
  logic [10:0] cur_bin_base, cur_bin_step;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every result strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.dds_load) load_cnt++;
      if (bus.sweep_done) done_cnt++;
      if (bus.result_valid) begin
        res_cnt++;
        if (sb_q.size() == 0) begin
          check("sb_unexpected_result", 64'(bus.point_idx), 64'hFFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("res_point_idx", 64'(bus.point_idx), 64'(e.idx));
          check("res_dds_ftw", 64'(bus.dds_ftw), 64'(e.ftw));
          check("res_reg_addr", 64'(bus.reg_addr), 64'(e.addr));
          if (bus.point_idx == 7'd1) begin
            seen_ftw1  = bus.dds_ftw;
            seen_addr1 = bus.reg_addr;
          end
        end
      end
    end
  end

  function automatic logic sig(input int sel);
    if (sel == SIG_FRST) return bus.fft_reset;
    return bus.busy;
  endfunction

  task automatic wait_level(input string name, input int sel, input logic lvl, input int budget);
    int n = 0;
    while (sig(sel) !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sig(sel) !== lvl) check(name, 64'(sig(sel)), 64'(lvl));
  endtask

  task automatic push_exp(input int i);
    exp_t e;
    e.idx  = i;
    e.ftw  = cur_ftw_base + cur_ftw_step * 32'(i);
    e.addr = 11'((32'(cur_bin_base) + 32'(cur_bin_step) * 32'(i)) % 2048);
    sb_q.push_back(e);
  endtask

  task automatic set_cfg(input vec_t v);
    cur_ftw_base = v.ftw_base;
    cur_ftw_step = v.ftw_step;
    cur_bin_base = v.bin_base;
    cur_bin_step = v.bin_step;
    bus.n_points       = 7'(v.n);
    bus.ftw_base       = v.ftw_base;
    bus.ftw_step       = v.ftw_step;
    bus.bin_base       = v.bin_base;
    bus.bin_step       = v.bin_step;
    bus.settle_cycles  = v.settle;
    bus.timeout_cycles = v.tmo;
  endtask

  task automatic start_sweep();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    check("load_latency", 64'(bus.dds_load), 64'd1);
  endtask

  // Drive one point: wait out the FFT reset pulse, then strobe fft_done.
  task automatic do_point(input int i, input int delay);
    wait_level("frst_rise", SIG_FRST, 1'b1, 2000);
    wait_level("frst_fall", SIG_FRST, 1'b0, 2000);
    if (delay >= 0) begin
      repeat (delay) @(negedge clk);
      push_exp(i);
      bus.fft_done = 1'b1;
      @(negedge clk) bus.fft_done = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int r0, d0, pts;
    set_cfg(v);
    r0 = res_cnt;
    d0 = done_cnt;
    seen_ftw1  = 'x;
    seen_addr1 = 'x;
    start_sweep();
    pts = (v.n > N_MAX) ? N_MAX : v.n;
    for (int i = 0; i < pts; i++) begin
      do_point(i, v.delay);
      if (v.delay < 0) break;
    end
    wait_level("sweep_end", SIG_BUSY, 1'b0, 5000);
    @(negedge clk);
    check("vec_results", 64'(res_cnt - r0), 64'(v.exp_res));
    check("vec_sweep_done", 64'(done_cnt - d0), 64'(v.exp_done));
    check("vec_timeout_err", 64'(bus.timeout_err), 64'(v.exp_tmo));
    check("vec_sb_empty", 64'(sb_q.size()), 64'd0);
    if (v.exp_res >= 2) begin
      check("vec_ftw_point1", 64'(seen_ftw1), 64'(v.exp_ftw1));
      check("vec_addr_point1", 64'(seen_addr1), 64'(v.exp_addr1));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_fft_reset"}, 64'(bus.fft_reset), 64'd1);
    check({tag, "_dds_ftw"}, 64'(bus.dds_ftw), 64'd0);
    check({tag, "_reg_addr"}, 64'(bus.reg_addr), 64'd0);
    check({tag, "_point_idx"}, 64'(bus.point_idx), 64'd0);
    check({tag, "_strobes"}, 64'({bus.dds_load, bus.result_valid, bus.sweep_done}), 64'd0);
    check({tag, "_timeout_err"}, 64'(bus.timeout_err), 64'd0);
  endtask

  vec_t vecs[6];
  vec_t h;

  initial begin
    int k, r0, d0, l0;
    vecs[0] = '{3, 32'h1000, 32'h100, 11'd10, 11'd5, 16'd8, 16'd0, 20, 3, 1, 1'b0, 32'h1100, 11'd15};
    vecs[1] = '{2, 32'hFFFFFF80, 32'h100, 11'd2046, 11'd3, 16'd0, 16'd0, 3, 2, 1, 1'b0, 32'h80, 11'd1};
    vecs[2] = '{1, 32'hABCD0000, 32'h1, 11'd0, 11'd0, 16'd1, 16'd0, 0, 1, 1, 1'b0, 32'h0, 11'd0};
    vecs[3] = '{100, 32'h0, 32'h01000000, 11'd0, 11'd32, 16'd0, 16'd0, 1, 64, 1, 1'b0, 32'h01000000, 11'd32};
    vecs[4] = '{2, 32'h5, 32'h5, 11'd7, 11'd7, 16'd3, 16'd10, 5, 2, 1, 1'b0, 32'hA, 11'd14};
    vecs[5] = '{1, 32'h77, 32'h1, 11'd5, 11'd1, 16'd2, 16'd6, -1, 0, 0, 1'b1, 32'h0, 11'd0};

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.fft_done = 1'b0;
    set_cfg(vecs[0]);

    repeat (3) @(negedge clk);
    check_reset_values("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("after_reset");

    foreach (vecs[i]) run_vec(vecs[i]);

    // Edge-exact timing with settle=8, plus a mid-sweep start and config change.
    h = '{2, 32'h2000, 32'h10, 11'd100, 11'd7, 16'd8, 16'd0, 0, 2, 1, 1'b0, 32'h2010, 11'd107};
    set_cfg(h);
    r0 = res_cnt; d0 = done_cnt; l0 = load_cnt;
    start_sweep();
    check("busy_after_start", 64'(bus.busy), 64'd1);
    k = 0;
    while (bus.fft_reset == 1'b0 && k < 100) begin @(negedge clk); k++; end
    check("settle_to_frst_cycles", 64'(k), 64'd9);
    k = 0;
    while (bus.fft_reset == 1'b1 && k < 100) begin @(negedge clk); k++; end
    check("frst_len", 64'(k), 64'(RSTC));
    push_exp(0);
    bus.fft_done = 1'b1;
    @(negedge clk) bus.fft_done = 1'b0;
    check("result_valid_e1", 64'(bus.result_valid), 64'd1);
    @(negedge clk);
    check("result_valid_one_cycle", 64'(bus.result_valid), 64'd0);
    bus.start = 1'b1;
    bus.ftw_step = 32'hDEAD0000;
    @(negedge clk) bus.start = 1'b0;
    check("next_load_e3", 64'(bus.dds_load), 64'd1);
    check("next_point_idx", 64'(bus.point_idx), 64'd1);
    do_point(1, 2);
    wait_level("timing_end", SIG_BUSY, 1'b0, 2000);
    @(negedge clk);
    check("timing_results", 64'(res_cnt - r0), 64'd2);
    check("timing_done", 64'(done_cnt - d0), 64'd1);
    check("midsweep_start_ignored", 64'(load_cnt - l0), 64'd2);
    check("timing_sb_empty", 64'(sb_q.size()), 64'd0);

    // Timeout after exactly 50 WAIT cycles.
    h = '{2, 32'h300, 32'h1, 11'd1, 11'd1, 16'd0, 16'd50, -1, 0, 0, 1'b1, 32'h0, 11'd0};
    set_cfg(h);
    d0 = done_cnt;
    start_sweep();
    do_point(0, -1);
    k = 0;
    while (bus.busy && k < 200) begin @(negedge clk); k++; end
    check("timeout_wait_cycles", 64'(k), 64'd50);
    check("timeout_err_set", 64'(bus.timeout_err), 64'd1);
    check("timeout_fft_reset", 64'(bus.fft_reset), 64'd1);
    @(negedge clk);
    check("timeout_no_done", 64'(done_cnt - d0), 64'd0);

    // Abort coinciding with fft_done in point 1.
    h = '{3, 32'h40, 32'h40, 11'd3, 11'd3, 16'd2, 16'd0, 1, 0, 0, 1'b0, 32'h0, 11'd0};
    set_cfg(h);
    r0 = res_cnt; d0 = done_cnt;
    start_sweep();
    check("timeout_err_cleared", 64'(bus.timeout_err), 64'd0);
    do_point(0, 1);
    wait_level("abort_frst_rise", SIG_FRST, 1'b1, 2000);
    wait_level("abort_frst_fall", SIG_FRST, 1'b0, 2000);
    @(negedge clk);
    bus.fft_done = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.fft_done = 1'b0;
    bus.abort = 1'b0;
    check("abort_idle", 64'(bus.busy), 64'd0);
    check("abort_no_result", 64'(bus.result_valid), 64'd0);
    @(negedge clk);
    check("abort_results", 64'(res_cnt - r0), 64'd1);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    run_vec(vecs[2]);

    // Zero points: a lone sweep_done and no DDS load.
    bus.n_points = '0;
    d0 = done_cnt; l0 = load_cnt;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    check("zero_pts_done", 64'(bus.sweep_done), 64'd1);
    check("zero_pts_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("zero_pts_done_once", 64'(bus.sweep_done), 64'd0);
    check("zero_pts_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("zero_pts_no_load", 64'(load_cnt - l0), 64'd0);

    // Asynchronous reset while settling, then a clean restart.
    h = '{2, 32'h9999, 32'h1, 11'd9, 11'd1, 16'd20, 16'd0, 0, 0, 0, 1'b0, 32'h0, 11'd0};
    set_cfg(h);
    start_sweep();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    @(negedge clk) rst = 1'b0;
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
